// File: rtl/mem_access_stage.sv
// MEM stage: data memory with sized little-endian loads/stores, load extension, debug word read, status.
// Latency: loads are combinational (0 cycles); stores commit at posedge; debug read is 1 cycle.
// Backpressure: enable_pipe_i=0 stalls (no side effects); halt_detected_i blocks store commit.
module mem_access_stage #(
   parameter int NB_DATA     = 32,
   parameter int NB_ADDR     = 7,
   parameter int NB_MEM_CTRL = 6,
   parameter int NB_CNT      = 16
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   enable_pipe_i,
   input  logic                   halt_detected_i,
   input  logic [NB_DATA-1:0]     alu_result_i,
   input  logic [NB_DATA-1:0]     data_write_i,
   input  logic [NB_MEM_CTRL-1:0] MEM_control_i,
   input  logic [NB_ADDR-1:0]     debug_addr_i,
   output logic [NB_DATA-1:0]     mem_data_o,
   output logic [NB_DATA-1:0]     debug_data_o,
   output logic                   misalign_o,
   output logic [NB_CNT-1:0]      store_count_o
);

   localparam int         DEPTH = 2**NB_ADDR;
   localparam logic [1:0] SZ_B  = 2'b00;
   localparam logic [1:0] SZ_H  = 2'b01;

   logic [NB_DATA-1:0] mem_q [DEPTH];
   logic [NB_DATA-1:0] debug_data_q, debug_data_d;
   logic               misalign_q, misalign_d;
   logic [NB_CNT-1:0]  store_count_q, store_count_d;

   logic               mem_write, mem_read, sign_ext;
   logic [1:0]         size;
   logic [NB_ADDR-1:0] word_idx;
   logic [1:0]         lane;
   logic               misaligned;
   logic [NB_DATA-1:0] rd_word;
   logic [7:0]         rd_byte;
   logic [15:0]        rd_half;
   logic [NB_DATA-1:0] mem_data_d;
   logic               wr_commit;
   logic [NB_DATA-1:0] wr_word_d;

   // Upper address bits wrap and control bit 0 is reserved; tie them off explicitly.
   logic unused_bits;
   assign unused_bits = ^{alu_result_i[NB_DATA-1:NB_ADDR+2], MEM_control_i[0]};

   // Decode the control bundle and check natural alignment for the access size.
   always_comb begin
      mem_write = MEM_control_i[5];
      mem_read  = MEM_control_i[4];
      sign_ext  = MEM_control_i[3];
      size      = MEM_control_i[2:1];
      word_idx  = alu_result_i[NB_ADDR+1:2];
      lane      = alu_result_i[1:0];
      case (size)
         SZ_B:    misaligned = 1'b0;
         SZ_H:    misaligned = lane[0];
         default: misaligned = |lane;   // word and reserved size
      endcase
   end

   // Combinational load path: select lane(s) and extend; zero when idle or misaligned.
   always_comb begin
      rd_word    = mem_q[word_idx];
      rd_byte    = rd_word[{lane, 3'b000} +: 8];
      rd_half    = rd_word[{lane[1], 4'b0000} +: 16];
      mem_data_d = '0;
      if (mem_read && !misaligned) begin
         case (size)
            SZ_B:    mem_data_d = {{(NB_DATA-8){sign_ext & rd_byte[7]}}, rd_byte};
            SZ_H:    mem_data_d = {{(NB_DATA-16){sign_ext & rd_half[15]}}, rd_half};
            default: mem_data_d = rd_word;
         endcase
      end
   end

   // Store merge: replace only the addressed lanes of the current word.
   always_comb begin
      wr_commit = mem_write & ~misaligned & enable_pipe_i & ~halt_detected_i;
      wr_word_d = rd_word;
      case (size)
         SZ_B:    wr_word_d[{lane, 3'b000} +: 8]     = data_write_i[7:0];
         SZ_H:    wr_word_d[{lane[1], 4'b0000} +: 16] = data_write_i[15:0];
         default: wr_word_d = data_write_i;
      endcase
   end

   // Next state for status, counter and the debug read register.
   always_comb begin
      misalign_d    = misalign_q | (enable_pipe_i & (mem_read | mem_write) & misaligned);
      store_count_d = store_count_q;
      if (wr_commit) begin
         store_count_d = store_count_q + NB_CNT'(1);
      end
      debug_data_d  = mem_q[debug_addr_i];   // sampled before this edge's write: read-before-write
   end

   // State registers; reset clears the whole memory array.
   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         debug_data_q  <= '0;
         misalign_q    <= 1'b0;
         store_count_q <= '0;
      end else begin
         if (wr_commit) begin
            mem_q[word_idx] <= wr_word_d;
         end
         debug_data_q  <= debug_data_d;
         misalign_q    <= misalign_d;
         store_count_q <= store_count_d;
      end
   end

   assign mem_data_o    = mem_data_d;
   assign debug_data_o  = debug_data_q;
   assign misalign_o    = misalign_q;
   assign store_count_o = store_count_q;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

   localparam logic [5:0] C_IDLE = 6'b000000;
   localparam logic [5:0] C_SW   = 6'b100110;
   localparam logic [5:0] C_LW   = 6'b010110;
   localparam logic [5:0] C_SWLW = 6'b110110;
   localparam logic [5:0] C_SB   = 6'b100000;
   localparam logic [5:0] C_LB   = 6'b011000;
   localparam logic [5:0] C_LBU  = 6'b010000;
   localparam logic [5:0] C_SH   = 6'b100010;
   localparam logic [5:0] C_LH   = 6'b011010;

   logic        clock_i;
   logic        reset_i;
   logic        enable_pipe_i;
   logic        halt_detected_i;
   logic [31:0] alu_result_i;
   logic [31:0] data_write_i;
   logic [5:0]  MEM_control_i;
   logic [6:0]  debug_addr_i;
   logic [31:0] mem_data_o;
   logic [31:0] debug_data_o;
   logic        misalign_o;
   logic [15:0] store_count_o;

   int tests  = 0;
   int errors = 0;
   bit check_en = 0;

   mem_access_stage dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .enable_pipe_i  (enable_pipe_i),
      .halt_detected_i(halt_detected_i),
      .alu_result_i   (alu_result_i),
      .data_write_i   (data_write_i),
      .MEM_control_i  (MEM_control_i),
      .debug_addr_i   (debug_addr_i),
      .mem_data_o     (mem_data_o),
      .debug_data_o   (debug_data_o),
      .misalign_o     (misalign_o),
      .store_count_o  (store_count_o)
   );

   initial begin
      clock_i = 0;
      forever #5 clock_i = ~clock_i;
   end

   // ---------------- behavioural model: byte-addressed memory ----------------
   logic [7:0]  mb [512];
   logic [31:0] m_dbg;
   logic        m_mis;
   logic [15:0] m_cnt;

   function automatic int nbytes(input logic [5:0] c);
      case (c[2:1])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] m_word(input int byte_addr);
      return {mb[(byte_addr+3) % 512], mb[(byte_addr+2) % 512], mb[(byte_addr+1) % 512], mb[byte_addr % 512]};
   endfunction

   function automatic logic [31:0] m_load(input logic [5:0] c, input logic [31:0] a);
      int n, base;
      logic [31:0] v;
      n = nbytes(c);
      if (!c[4] || (a % n) != 0) return 32'h0;
      base = int'(a % 512);
      v = m_word(base);
      if (n == 1) return c[3] ? 32'(signed'(v[7:0]))  : {24'h0, v[7:0]};
      if (n == 2) return c[3] ? 32'(signed'(v[15:0])) : {16'h0, v[15:0]};
      return v;
   endfunction

   always @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         for (int i = 0; i < 512; i++) mb[i] = 8'h0;
         m_dbg = 0; m_mis = 0; m_cnt = 0;
      end else begin
         int n, a;
         m_dbg = m_word(int'(debug_addr_i) * 4);
         n = nbytes(MEM_control_i);
         a = int'(alu_result_i % 512);
         if (enable_pipe_i && (MEM_control_i[5] || MEM_control_i[4])) begin
            if ((a % n) != 0) m_mis = 1;
            else if (MEM_control_i[5] && !halt_detected_i) begin
               for (int k = 0; k < n; k++) mb[a + k] = data_write_i[8*k +: 8];
               m_cnt = m_cnt + 1;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, away from the active edge.
   always @(negedge clock_i) begin
      if (check_en) begin
         chk("mem_data",    mem_data_o, m_load(MEM_control_i, alu_result_i));
         chk("debug_data",  debug_data_o, m_dbg);
         chk("misalign",    {31'b0, misalign_o}, {31'b0, m_mis});
         chk("store_count", {16'b0, store_count_o}, {16'b0, m_cnt});
      end
   end

   task automatic drive(input logic [5:0] c, input logic [31:0] a, input logic [31:0] d,
                        input logic en, input logic halt, input logic [6:0] dbg);
      @(posedge clock_i);
      #2;
      MEM_control_i   = c;
      alu_result_i    = a;
      data_write_i    = d;
      enable_pipe_i   = en;
      halt_detected_i = halt;
      debug_addr_i    = dbg;
   endtask

   initial begin
      reset_i = 0;
      // Reset held with an active store: nothing may be written.
      MEM_control_i = C_SW; alu_result_i = 32'h10; data_write_i = 32'hDEADBEEF;
      enable_pipe_i = 1; halt_detected_i = 0; debug_addr_i = 7'd4;
      #1 check_en = 1;
      repeat (3) @(posedge clock_i);
      @(negedge clock_i);
      chk("rst_count", {16'b0, store_count_o}, 32'h0);
      chk("rst_misalign", {31'b0, misalign_o}, 32'h0);
      chk("rst_debug", debug_data_o, 32'h0);
      drive(C_IDLE, 0, 0, 1, 0, 7'd4);
      reset_i = 1;

      // SW then LW
      drive(C_SW, 32'h10, 32'hDEADBEEF, 1, 0, 7'd4);
      drive(C_LW, 32'h10, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("lw_after_sw", mem_data_o, 32'hDEADBEEF);
      chk("count_1", {16'b0, store_count_o}, 32'd1);

      // SB then LB / LBU
      drive(C_SB, 32'h13, 32'h00000080, 1, 0, 7'd4);
      drive(C_LB, 32'h13, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("lb", mem_data_o, 32'hFFFFFF80);
      drive(C_LBU, 32'h13, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("lbu", mem_data_o, 32'h00000080);
      drive(C_LW, 32'h10, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("word_after_sb", mem_data_o, 32'h80ADBEEF);

      // Misaligned SH: suppressed, sticky flag
      drive(C_SH, 32'h11, 32'h0000FFFF, 1, 0, 7'd4);
      drive(C_LW, 32'h10, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("sh_mis_word", mem_data_o, 32'h80ADBEEF);
      chk("sh_mis_flag", {31'b0, misalign_o}, 32'h1);
      chk("sh_mis_count", {16'b0, store_count_o}, 32'd2);
      drive(C_LH, 32'h11, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("lh_mis_zero", mem_data_o, 32'h0);
      drive(C_LH, 32'h12, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("lh_signed", mem_data_o, 32'hFFFF80AD);
      drive(C_IDLE, 0, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("mis_sticky", {31'b0, misalign_o}, 32'h1);

      // Stalled store, then halted store, then debug read of word 8
      drive(C_SW, 32'h20, 32'hCAFEF00D, 0, 0, 7'd4);
      drive(C_SW, 32'h20, 32'hCAFEF00D, 1, 1, 7'd4);
      drive(C_IDLE, 0, 0, 1, 0, 7'd8);
      @(posedge clock_i);
      @(negedge clock_i);
      chk("stall_halt_dbg", debug_data_o, 32'h0);
      chk("stall_halt_cnt", {16'b0, store_count_o}, 32'd2);

      // Debug read-before-write on the same word
      drive(C_SW, 32'h10, 32'h12345678, 1, 0, 7'd4);
      drive(C_IDLE, 0, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("dbg_old", debug_data_o, 32'h80ADBEEF);
      @(negedge clock_i);
      chk("dbg_new", debug_data_o, 32'h12345678);

      // Same-cycle write+read shows pre-write data; upper address bits wrap
      drive(C_SWLW, 32'h210, 32'hAAAA5555, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("wr_rd_old", mem_data_o, 32'h12345678);
      drive(C_LW, 32'h10, 0, 1, 0, 7'd4);
      @(negedge clock_i);
      chk("wrap_new", mem_data_o, 32'hAAAA5555);
      chk("count_4", {16'b0, store_count_o}, 32'd4);

      // Stalled load still reflects inputs combinationally
      drive(C_LBU, 32'h11, 0, 0, 0, 7'd4);
      @(negedge clock_i);
      chk("stall_load", mem_data_o, 32'h00000055);

      drive(C_IDLE, 0, 0, 1, 0, 7'd0);
      repeat (2) @(negedge clock_i);
      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
